fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single 8-bit `fifo` write port among N_REQ independent producers. Each producer offers data via a valid/ready handshake. The arbiter grants one producer at a time and locks that grant for a burst until `last` or MAX_BURST beats. It then drives the FIFO's `wr_en`/`din` and honours `full` back-pressure, and sits directly in front of the `fifo` instance.

## Interface
- N_REQ, 4, number of producers (2..16)
- DATA_W, 8, data width; must equal FIFO width
- MAX_BURST, 8, maximum beats per grant (1..255)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  producer i has a beat
- req_data  in  N_REQ×DATA_W  packed; producer i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  beat is last of producer i's burst
- req_ready  out  N_REQ  beat of producer i accepted this cycle if valid
- fifo_wr_en  out  1  to FIFO `wr_en`
- fifo_din  out  DATA_W  to FIFO `din`
- fifo_full  in  1  from FIFO `full`
- grant_id  out  $clog2(N_REQ)  current or most recent owner
- busy  out  1  high while in ARB_BURST

## Operation
- FSM with two states.
- ARB_IDLE:
  - req_ready = 0, fifo_wr_en = 0, fifo_din = 0.
  - If any req_valid is high, pick the first set bit searching from (last_owner+1) mod N_REQ upward with wrap.
  - Register the pick into owner and grant_id. Go to ARB_BURST and clear beat_cnt.
- ARB_BURST (combinational outputs):
  - req_ready[owner] = !fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[owner] && !fifo_full.
  - fifo_din = req_data[owner].
  - A transfer is a cycle with fifo_wr_en = 1. On each transfer, beat_cnt increments.
- Burst exit: after a transfer where req_last[owner] = 1 or beat_cnt+1 == MAX_BURST, go to ARB_IDLE and set last_owner <= owner.
- Owner deasserting valid mid-burst does not release the grant. The arbiter waits, with no timeout.
- Non-owner valid/data/last are ignored. No beat is ever dropped or duplicated.
- fifo_full gates the transfer. beat_cnt, owner and state hold while full.
- Reset values:
  - state = ARB_IDLE, last_owner = N_REQ-1 (producer 0 has first priority), grant_id = 0, beat_cnt = 0.
  - Outputs: req_ready = 0, fifo_wr_en = 0, fifo_din = 0, busy = 0.
- Reset asserted mid-burst: all outputs go to reset values immediately (asynchronous). The partial burst is abandoned; producers must restart it.
- Width: beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1 while registered.

## Timing
- Arbitration costs one cycle.
  - A valid sampled in ARB_IDLE at edge k gives busy = 1 and the first possible transfer in cycle k→k+1.
  - Between bursts there is always exactly one ARB_IDLE cycle.
- Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- req_ready and fifo_wr_en depend combinationally on fifo_full and req_valid. There are no combinational paths from req_ready back to inputs.
- A write lands in the FIFO at the clock edge ending the transfer cycle.

## Structure
- Package `fifo_arb_pkg` contains:
  - typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e
  - default parameter constants
- Sub-module `rr_pick`: purely combinational round-robin selector.
  - Inputs: req vector and last_owner.
  - Outputs: grant index and any_req.
  - Reusable by other arbiters.
- Top level holds the FSM, beat counter and output mux.

## Test plan
- Reset: rst_n low for 2 cycles with all req_valid = 1, then released. Required: all outputs 0 during reset; grant_id = 0 after the first arbitration cycle.
- Single burst: producer 1 sends 0x11, 0x22, 0x33 with last on 0x33. Required: one IDLE cycle, then three consecutive fifo writes 0x11/0x22/0x33 with grant_id = 1, then busy = 0.
- Fairness: all four producers continuously valid with last = 1 on every beat. Required: grants in order 0, 1, 2, 3, 0 with one write every 2 cycles.
- Burst cap: producer 2 streams 0x00..0x09 with no last and is the only requester. Required: 8 writes (0x00..0x07), one IDLE cycle, re-grant to 2, then writes 0x08, 0x09.
- Back-pressure: fifo_full high for 3 cycles mid-burst while owner valid with 0xA5. Required: wr_en = 0 and req_ready = 0 for those 3 cycles, beat_cnt unchanged; 0xA5 is written once on the first cycle after full drops.
- Stalled owner: producer 0 owns and drops valid for 4 cycles while producer 3 is valid. Required: req_ready[3] = 0 throughout and no writes. Burst resumes with producer 0; producer 3 is granted next.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshakes plus FIFO write port seen by the arbiter.
// Latency: n/a (wires only).
// Backpressure: fifo_full flows toward the arbiter, which turns it into req_ready.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = fifo_arb_pkg::DEF_N_REQ,
    parameter int DATA_W = fifo_arb_pkg::DEF_DATA_W
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_din;
    logic                    fifo_full;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;

    // master: the arbiter itself
    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_din, grant_id, busy
    );

    // slave: producers and FIFO around the arbiter
    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after last_owner, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_owner,
    output logic [ID_W-1:0]  grant,
    output logic             any_req
);

    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        any_req = |req;
        // Walk offsets from farthest to nearest so the nearest requester wins.
        for (int off = N_REQ; off >= 1; off--) begin
            idx = (int'(last_owner) + off) % N_REQ;
            if (req[ID_W'(idx)]) begin
                grant = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Latency: one idle arbitration cycle per grant, then one beat per cycle combinationally.
// Backpressure: fifo_full deasserts the owner's req_ready and wr_en; all state holds.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_wr_arbiter_if.master  bus
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ID_W-1:0]   pick;
    logic              any_req;
    logic              xfer;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req        (bus.req_valid),
        .last_owner (last_owner_q),
        .grant      (pick),
        .any_req    (any_req)
    );

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_owner_d   = last_owner_q;
        beat_cnt_d     = beat_cnt_q;
        xfer           = 1'b0;
        bus.req_ready  = '0;
        bus.fifo_wr_en = 1'b0;
        bus.fifo_din   = '0;

        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = ARB_BURST;
                end
            end
            ARB_BURST: begin
                bus.req_ready[owner_q] = !bus.fifo_full;
                bus.fifo_din           = bus.req_data[int'(owner_q)*DATA_W +: DATA_W];
                xfer                   = bus.req_valid[owner_q] && !bus.fifo_full;
                bus.fifo_wr_en         = xfer;
                if (xfer) begin
                    // Counter is cleared on exit so it never registers MAX_BURST.
                    if (bus.req_last[owner_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d      = ARB_IDLE;
                        last_owner_d = owner_q;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_owner_q <= ID_W'(N_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign bus.grant_id = owner_q;
    assign bus.busy     = (state_q == ARB_BURST);

endmodule
